// File: rtl/enc_spi_host.sv
// enc_spi_host: SPI mode-0 master for one AES encrypt transaction.
// Sends a 49-byte request frame, waits, then reads 16 ciphertext bytes.
module enc_spi_host #(
  parameter int CLK_DIV   = 4,
  parameter int BYTE_GAP  = 8,
  parameter int RESP_WAIT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] i_data,
  input  logic [255:0] i_key,
  input  logic [7:0]   key_len,
  output logic         cs,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] o_data
);

  localparam int MAX_AB = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
  localparam int MAXC   = (MAX_AB > RESP_WAIT) ? MAX_AB : RESP_WAIT;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DIV_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_L = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] TRN_L = CW'(RESP_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, TX_BYTE, TX_GAP,
    TURN, RX_BYTE, RX_GAP, HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [391:0]  frame_q, frame_d;
  logic [127:0]  rx_q, rx_d;
  logic [2:0]    bit_q, bit_d;
  logic [5:0]    byte_q, byte_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          phase_q, phase_d;

  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [127:0]  odata_q, odata_d;

  logic          key_ok;
  logic          accept;
  logic [255:0]  key_m;

  assign key_ok = (key_len == 8'd16) ||
                  (key_len == 8'd24) ||
                  (key_len == 8'd32);
  assign accept = (state_q == IDLE) && start && key_ok;

  // Bytes beyond key_len go out as zero.
  always_comb begin
    key_m = i_key;
    if (key_len == 8'd16) begin
      key_m[127:0] = '0;
    end else if (key_len == 8'd24) begin
      key_m[63:0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      div_q   <= '0;
      wait_q  <= '0;
      phase_q <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      div_q   <= div_d;
      wait_q  <= wait_d;
      phase_q <= phase_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    div_d   = div_q;
    wait_d  = wait_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = {i_data, key_len, key_m};
          state_d = SETUP;
          wait_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      SETUP, TX_GAP, RX_GAP, TURN: begin
        if ((state_q == SETUP  && wait_q == DIV_L) ||
            (state_q == TX_GAP && wait_q == GAP_L) ||
            (state_q == RX_GAP && wait_q == GAP_L) ||
            (state_q == TURN   && wait_q == TRN_L)) begin
          wait_d  = '0;
          div_d   = '0;
          phase_d = 1'b0;
          if (state_q == TURN) begin
            byte_d = '0;
          end
          if (state_q == TURN || state_q == RX_GAP) begin
            state_d = RX_BYTE;
          end else begin
            state_d = TX_BYTE;
          end
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      TX_BYTE, RX_BYTE: begin
        if (div_q != DIV_L) begin
          div_d = div_q + CW'(1);
        end else begin
          div_d   = '0;
          phase_d = ~phase_q;
          // Rising sclk edge: sample miso while the slave holds it.
          if (!phase_q) begin
            if (state_q == RX_BYTE) begin
              rx_d = {rx_q[126:0], miso};
            end
          end else begin
            bit_d = bit_q + 3'd1;
            if (state_q == TX_BYTE) begin
              frame_d = {frame_q[390:0], 1'b0};
            end
            if (bit_q == 3'd7) begin
              wait_d = '0;
              byte_d = byte_q + 6'd1;
              if (state_q == TX_BYTE) begin
                if (byte_q == 6'd48) begin
                  state_d = TURN;
                  byte_d  = '0;
                end else begin
                  state_d = TX_GAP;
                end
              end else if (byte_q == 6'd15) begin
                state_d = HOLD;
              end else begin
                state_d = RX_GAP;
              end
            end
          end
        end
      end
      HOLD: begin
        if (wait_q == DIV_L) begin
          state_d = IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin registers follow the next state so they change on the same edge.
  always_comb begin
    cs_d    = (state_d == IDLE);
    sclk_d  = ((state_d == TX_BYTE) ||
               (state_d == RX_BYTE)) && phase_d;
    mosi_d  = 1'b0;
    if ((state_d == SETUP)   ||
        (state_d == TX_BYTE) ||
        (state_d == TX_GAP)) begin
      mosi_d = frame_d[391];
    end
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == HOLD) && (state_d == IDLE);
    err_d   = (state_q == IDLE) && start && !key_ok;
    odata_d = done_d ? rx_q : odata_q;
  end

  assign cs     = cs_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign o_data = odata_q;

endmodule
